// File: rtl/rns_pkg.sv
// Shared constants and types for the RNS subtract-correction datapath.
// Each correction constant is below its modulus, so one conditional add undoes any borrow.
package rns_pkg;

  localparam int unsigned NUM_RNS_DIGITS = 8;

  localparam int unsigned MODULI [NUM_RNS_DIGITS] = '{
    177147, 78125, 117649, 161051, 83521, 130321, 131072, 259081
  };
  localparam int unsigned COR_C1 [NUM_RNS_DIGITS] = '{
    33343, 1000, 2000, 3000, 4000, 5000, 6000, 7000
  };
  localparam int unsigned COR_C2 [NUM_RNS_DIGITS] = '{
    143804, 50000, 60000, 70000, 80000, 90000, 100000, 110000
  };

  typedef enum logic [1:0] {
    CorNone = 2'd0,
    CorSub1 = 2'd1,
    CorSub2 = 2'd2,
    CorRsvd = 2'd3
  } cor_sel_e;

endpackage

// File: rtl/sub_cor_stage_np_if.sv
// Valid/ready word interface of the subtract-correction stage.
// The slave modport is the stage itself; the master modport is its environment.
interface sub_cor_stage_np_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned CNT_WIDTH  = 16
);

  logic                                 in_valid;
  logic                                 in_ready;
  logic [NUM_DIGITS-1:0][DATA_WIDTH-1:0] dig_in;
  logic [1:0]                           sign_in;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [NUM_DIGITS-1:0][DATA_WIDTH-1:0] result;
  logic [NUM_DIGITS-1:0]                digit_err;
  logic                                 sign_err;
  logic [CNT_WIDTH-1:0]                 err_count;

  modport slave (
    input  in_valid, dig_in, sign_in, out_ready,
    output in_ready, out_valid, result, digit_err, sign_err, err_count
  );

  modport master (
    output in_valid, dig_in, sign_in, out_ready,
    input  in_ready, out_valid, result, digit_err, sign_err, err_count
  );

endinterface

// File: rtl/mod_sub_digit.sv
// One residue digit: S1 registers the signed difference, S2 folds it back into [0, MODULUS).
module mod_sub_digit
  import rns_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned MODULUS    = 177147,
  parameter int unsigned C1         = 33343,
  parameter int unsigned C2         = 143804
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_en_i,
  input  logic                  s2_en_i,
  input  logic [DATA_WIDTH-1:0] dig_i,
  input  cor_sel_e              sel_i,
  output logic                  range_err_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  digit_err_o
);

  localparam logic [DATA_WIDTH-1:0] ModW = DATA_WIDTH'(MODULUS);
  localparam logic [DATA_WIDTH-1:0] CorC1 = DATA_WIDTH'(C1);
  localparam logic [DATA_WIDTH-1:0] CorC2 = DATA_WIDTH'(C2);

  logic [DATA_WIDTH-1:0]        cor;
  logic signed [DATA_WIDTH:0]   diff_d, diff_q;
  logic                         derr_s1_d, derr_s1_q;
  logic [DATA_WIDTH-1:0]        wrapped;
  logic [DATA_WIDTH-1:0]        res_d, res_q;
  logic                         derr_s2_q;

  always_comb begin
    cor = '0;
    unique case (sel_i)
      CorSub1:          cor = CorC1;
      CorSub2:          cor = CorC2;
      CorNone, CorRsvd: cor = '0;
    endcase
    derr_s1_d = (dig_i >= ModW);
    diff_d    = $signed({1'b0, dig_i}) - $signed({1'b0, cor});
  end

  // Modular add only needs the low bits; the borrow is cancelled by adding MODULUS.
  always_comb begin
    wrapped = diff_q[DATA_WIDTH-1:0] + ModW;
    if (derr_s1_q) begin
      res_d = '0;
    end else if (diff_q[DATA_WIDTH]) begin
      res_d = wrapped;
    end else begin
      res_d = diff_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      derr_s1_q <= 1'b0;
      res_q     <= '0;
      derr_s2_q <= 1'b0;
    end else begin
      if (s1_en_i) begin
        diff_q    <= diff_d;
        derr_s1_q <= derr_s1_d;
      end
      if (s2_en_i) begin
        res_q     <= res_d;
        derr_s2_q <= derr_s1_q;
      end
    end
  end

  assign range_err_o = derr_s1_d;
  assign result_o    = res_q;
  assign digit_err_o = derr_s2_q;

endmodule

// File: rtl/sub_cor_stage_np.sv
// Two-stage residue subtract-correction with bubble-collapsing valid/ready control
// and a saturating count of erroneous words.
module sub_cor_stage_np
  import rns_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              rst_n,
  sub_cor_stage_np_if.slave bus
);

  logic                                  s1_valid_d, s1_valid_q;
  logic                                  s2_valid_d, s2_valid_q;
  logic                                  s1_load, s2_load;
  logic                                  s1_en, s2_en;
  logic                                  sign_err_s1_d, sign_err_s1_q;
  logic                                  sign_err_s2_q;
  logic [CNT_WIDTH-1:0]                  cnt_d, cnt_q;
  logic [NUM_DIGITS-1:0]                 range_err;
  logic [NUM_DIGITS-1:0][DATA_WIDTH-1:0] res;
  logic [NUM_DIGITS-1:0]                 derr;
  cor_sel_e                              sel;

  assign sel = cor_sel_e'(bus.sign_in);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    mod_sub_digit #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODULUS    (MODULI[i]),
      .C1         (COR_C1[i]),
      .C2         (COR_C2[i])
    ) u_digit (
      .clk         (clk),
      .rst_n       (rst_n),
      .s1_en_i     (s1_en),
      .s2_en_i     (s2_en),
      .dig_i       (bus.dig_in[i]),
      .sel_i       (sel),
      .range_err_o (range_err[i]),
      .result_o    (res[i]),
      .digit_err_o (derr[i])
    );
  end

  // Data registers only move with a real word, so outputs stay put across bubbles.
  always_comb begin
    s2_load       = !s2_valid_q || bus.out_ready;
    s1_load       = !s1_valid_q || s2_load;
    s1_en         = s1_load && bus.in_valid;
    s2_en         = s2_load && s1_valid_q;
    s1_valid_d    = s1_load ? bus.in_valid : s1_valid_q;
    s2_valid_d    = s2_load ? s1_valid_q : s2_valid_q;
    sign_err_s1_d = (sel == CorRsvd);
    cnt_d         = cnt_q;
    if (s1_en && ((|range_err) || sign_err_s1_d) && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      sign_err_s1_q <= 1'b0;
      sign_err_s2_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      cnt_q      <= cnt_d;
      if (s1_en) begin
        sign_err_s1_q <= sign_err_s1_d;
      end
      if (s2_en) begin
        sign_err_s2_q <= sign_err_s1_q;
      end
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.result    = res;
  assign bus.digit_err = derr;
  assign bus.sign_err  = sign_err_s2_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_sub_cor_stage_np.sv
// Directed bench for sub_cor_stage_np: latency, correction values, errors, stalls, reset, saturation.
module tb_sub_cor_stage_np;

  localparam int unsigned ND = 8;
  localparam int unsigned DW = 18;
  localparam int unsigned CW = 4;

  typedef logic [ND-1:0][DW-1:0] word_t;

  localparam int unsigned TB_MOD [ND] = '{
    177147, 78125, 117649, 161051, 83521, 130321, 131072, 259081
  };
  localparam int unsigned TB_C1 [ND] = '{
    33343, 1000, 2000, 3000, 4000, 5000, 6000, 7000
  };
  localparam int unsigned TB_C2 [ND] = '{
    143804, 50000, 60000, 70000, 80000, 90000, 100000, 110000
  };

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sub_cor_stage_np_if #(.NUM_DIGITS(ND), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  sub_cor_stage_np #(
    .NUM_DIGITS (ND),
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int in_acc   = 0;
  word_t         got_res[$];
  logic [ND-1:0] got_derr[$];
  logic          got_serr[$];

  function automatic word_t fill(logic [DW-1:0] v);
    word_t w;
    for (int i = 0; i < int'(ND); i++) w[i] = v;
    return w;
  endfunction

  function automatic word_t model(word_t dig, logic [1:0] sel);
    word_t r;
    int    dd;
    for (int i = 0; i < int'(ND); i++) begin
      if (int'(dig[i]) >= int'(TB_MOD[i])) begin
        r[i] = '0;
      end else begin
        dd = int'(dig[i]);
        if (sel == 2'd1) dd = dd - int'(TB_C1[i]);
        else if (sel == 2'd2) dd = dd - int'(TB_C2[i]);
        if (dd < 0) dd = dd + int'(TB_MOD[i]);
        r[i] = DW'(dd);
      end
    end
    return r;
  endfunction

  // One clock: log handshakes just before the edge, return 1ns after it.
  task automatic step();
    @(negedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      got_res.push_back(bus.result);
      got_derr.push_back(bus.digit_err);
      got_serr.push_back(bus.sign_err);
    end
    if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) in_acc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    got_res.delete();
    got_derr.delete();
    got_serr.delete();
    in_acc = 0;
  endtask

  task automatic apply_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
  endtask

  task automatic send_word(word_t d, logic [1:0] s);
    int start;
    start        = in_acc;
    bus.dig_in   = d;
    bus.sign_in  = s;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && in_acc == start; k++) step();
    bus.in_valid = 1'b0;
    checks++;
    if (in_acc == start) begin
      failures++;
      $display("FAIL send_accept: word not accepted, in_acc=%0d required %0d", in_acc, start + 1);
    end
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.dig_in    = '0;
    bus.sign_in   = 2'd0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++; $display("FAIL rst_in_ready: got %b required 1", bus.in_ready);
    end
    checks++;
    if (bus.result !== word_t'(0)) begin
      failures++; $display("FAIL rst_result: got %h required 0", bus.result);
    end
    checks++;
    if (bus.digit_err !== '0 || bus.sign_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_err_flags: got derr=%h serr=%b required 0/0", bus.digit_err, bus.sign_err);
    end
    checks++;
    if (bus.err_count !== '0) begin
      failures++; $display("FAIL rst_err_count: got %0d required 0", bus.err_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_idle: got out_valid=%b in_ready=%b required 0/1",
               bus.out_valid, bus.in_ready);
    end
    clear_log();
  endtask

  task automatic test_baseline();
    word_t w;
    clear_log();
    w             = fill(18'h12345);
    bus.out_ready = 1'b1;
    bus.dig_in    = w;
    bus.sign_in   = 2'd0;
    bus.in_valid  = 1'b1;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL base_latency1: out_valid=%b required 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== w) begin
      failures++;
      $display("FAIL base_latency2: out_valid=%b result=%h required 1/%h",
               bus.out_valid, bus.result, w);
    end
    step();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (got_res.size() != 3) begin
      failures++; $display("FAIL base_count: got %0d words required 3", got_res.size());
    end
    for (int n = 0; n < got_res.size(); n++) begin
      checks++;
      if (got_res[n] !== w || got_derr[n] !== '0) begin
        failures++;
        $display("FAIL base_word%0d: got %h derr=%h required %h derr=0",
                 n, got_res[n], got_derr[n], w);
      end
    end
  endtask

  task automatic test_sign();
    logic [DW-1:0] d0  [3];
    logic [1:0]    sel [3];
    logic [DW-1:0] exp0[3];
    word_t         w;
    d0   = '{18'd74565, 18'd74565, 18'd0};
    sel  = '{2'd1, 2'd2, 2'd1};
    exp0 = '{18'd41222, 18'd107908, 18'd143804};
    for (int v = 0; v < 3; v++) begin
      clear_log();
      w    = fill(18'h12345);
      w[0] = d0[v];
      send_word(w, sel[v]);
      checks++;
      if (got_res.size() != 1) begin
        failures++; $display("FAIL sign%0d_count: got %0d words required 1", v, got_res.size());
      end else begin
        checks++;
        if (got_res[0][0] !== exp0[v]) begin
          failures++;
          $display("FAIL sign%0d_digit0: got %0d required %0d", v, got_res[0][0], exp0[v]);
        end
        checks++;
        if (got_res[0] !== model(w, sel[v])) begin
          failures++;
          $display("FAIL sign%0d_word: got %h required %h", v, got_res[0], model(w, sel[v]));
        end
      end
    end
  endtask

  task automatic test_range();
    word_t w;
    apply_reset();
    w    = fill(18'h12345);
    w[0] = 18'd177147;
    send_word(w, 2'd0);
    checks++;
    if (got_res.size() != 1) begin
      failures++; $display("FAIL range_count: got %0d words required 1", got_res.size());
    end else begin
      checks++;
      if (got_derr[0] !== 8'h01 || got_serr[0] !== 1'b0) begin
        failures++;
        $display("FAIL range_flags: got derr=%h serr=%b required 01/0", got_derr[0], got_serr[0]);
      end
      checks++;
      if (got_res[0][0] !== '0 || got_res[0] !== model(w, 2'd0)) begin
        failures++;
        $display("FAIL range_word: got %h required %h", got_res[0], model(w, 2'd0));
      end
    end
    checks++;
    if (bus.err_count !== 4'd1) begin
      failures++; $display("FAIL range_cnt1: got %0d required 1", bus.err_count);
    end
    clear_log();
    for (int i = 0; i < int'(ND); i++) w[i] = DW'(1000 * i + 7);
    send_word(w, 2'd3);
    checks++;
    if (got_res.size() != 1) begin
      failures++; $display("FAIL rsvd_count: got %0d words required 1", got_res.size());
    end else begin
      checks++;
      if (got_serr[0] !== 1'b1 || got_derr[0] !== '0) begin
        failures++;
        $display("FAIL rsvd_flags: got serr=%b derr=%h required 1/00", got_serr[0], got_derr[0]);
      end
      checks++;
      if (got_res[0] !== w) begin
        failures++; $display("FAIL rsvd_word: got %h required %h", got_res[0], w);
      end
    end
    checks++;
    if (bus.err_count !== 4'd2) begin
      failures++; $display("FAIL rsvd_cnt2: got %0d required 2", bus.err_count);
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    bus.sign_in = 2'd0;
    for (int t = 0; t < 40 && got_res.size() < 6; t++) begin
      bus.out_ready = !(t >= 2 && t < 6);
      bus.in_valid  = (in_acc < 6);
      bus.dig_in    = fill(DW'(32'h12345 + in_acc));
      #1;
      if (t == 3) begin
        checks++;
        if (bus.in_ready !== 1'b0 || in_acc != 2) begin
          failures++;
          $display("FAIL bp_in_ready: got in_ready=%b accepted=%0d required 0/2",
                   bus.in_ready, in_acc);
        end
      end
      if (t == 3 || t == 5) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== fill(18'h12345)) begin
          failures++;
          $display("FAIL bp_hold_t%0d: got out_valid=%b result=%h required 1/%h",
                   t, bus.out_valid, bus.result, fill(18'h12345));
        end
      end
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got_res.size() != 6 || in_acc != 6) begin
      failures++;
      $display("FAIL bp_count: got %0d out / %0d in required 6/6", got_res.size(), in_acc);
    end
    for (int n = 0; n < got_res.size(); n++) begin
      checks++;
      if (got_res[n] !== fill(DW'(32'h12345 + n))) begin
        failures++;
        $display("FAIL bp_word%0d: got %h required %h", n, got_res[n], fill(DW'(32'h12345 + n)));
      end
    end
  endtask

  task automatic test_reset_midstream();
    word_t w;
    apply_reset();
    w             = fill(18'h12345);
    w[0]          = 18'd177147;
    bus.out_ready = 1'b0;
    bus.dig_in    = w;
    bus.sign_in   = 2'd0;
    bus.in_valid  = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.err_count !== 4'd2) begin
      failures++;
      $display("FAIL mid_full: got out_valid=%b in_ready=%b cnt=%0d required 1/0/2",
               bus.out_valid, bus.in_ready, bus.err_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_count !== '0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: got out_valid=%b cnt=%0d in_ready=%b required 0/0/1",
               bus.out_valid, bus.err_count, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    bus.out_ready = 1'b1;
    bus.dig_in    = fill(18'd500);
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++; $display("FAIL mid_lat1: out_valid=%b required 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== fill(18'd500)) begin
      failures++;
      $display("FAIL mid_lat2: got out_valid=%b result=%h required 1/%h",
               bus.out_valid, bus.result, fill(18'd500));
    end
    step();
    step();
    checks++;
    if (got_res.size() != 1 || in_acc != 1) begin
      failures++;
      $display("FAIL mid_words: got %0d out / %0d in required 1/1", got_res.size(), in_acc);
    end
  endtask

  task automatic test_saturation();
    word_t w;
    bit    seen14, seen15;
    apply_reset();
    seen14        = 1'b0;
    seen15        = 1'b0;
    w             = fill(18'h00100);
    w[0]          = 18'd200000;
    bus.out_ready = 1'b1;
    bus.dig_in    = w;
    bus.sign_in   = 2'd0;
    bus.in_valid  = 1'b1;
    for (int k = 0; k < 60 && in_acc < 20; k++) begin
      step();
      if (in_acc == 14 && !seen14) begin
        seen14 = 1'b1;
        checks++;
        if (bus.err_count !== 4'd14) begin
          failures++; $display("FAIL sat_cnt14: got %0d required 14", bus.err_count);
        end
      end
      if (in_acc == 15 && !seen15) begin
        seen15 = 1'b1;
        checks++;
        if (bus.err_count !== 4'd15) begin
          failures++; $display("FAIL sat_cnt15: got %0d required 15", bus.err_count);
        end
      end
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (in_acc != 20 || bus.err_count !== 4'd15) begin
      failures++;
      $display("FAIL sat_hold: got accepted=%0d cnt=%0d required 20/15", in_acc, bus.err_count);
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_sign();
    test_range();
    test_backpressure();
    test_reset_midstream();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
